// File: rtl/qc_fix_pkg.sv
// Shared fixed-point definitions for the complex gate datapath.
// Operands are Q(FIX_BITS-2) two's complement: ONE = 2^(FIX_BITS-2).
package qc_fix_pkg;

    localparam int REAL = 0;
    localparam int IMAG = 1;

    localparam int FIX_BITS = 37;
    localparam int FIX_FRAC = FIX_BITS - 2;

    typedef logic [0:1][FIX_BITS-1:0] cplx_t;

    localparam logic [FIX_BITS-1:0] ONE = FIX_BITS'(1) << FIX_FRAC;

endpackage

// File: rtl/complex_fix_mul_clocked.sv
// Two-stage pipelined complex fixed-point multiplier.
// available pulses two cycles after ready; product is floor-scaled by 2^-(IN_BITS-2).
module complex_fix_mul_clocked
    import qc_fix_pkg::*;
#(
    parameter int IN_BITS  = 37,
    parameter int OUT_BITS = 38
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ready,
    input  logic [0:1][IN_BITS-1:0]      a,
    input  logic [0:1][IN_BITS-1:0]      b,
    output logic                         available,
    output logic [0:1][OUT_BITS-1:0]     p
);

    localparam int FRAC = IN_BITS - 2;
    localparam int PW   = 2 * IN_BITS + 1;

    logic                    v1;
    logic [0:1][IN_BITS-1:0] a_q;
    logic [0:1][IN_BITS-1:0] b_q;

    logic signed [PW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] re_full, im_full;
    logic                 unused_bits;

    always_comb begin
        ar      = PW'($signed(a_q[REAL]));
        ai      = PW'($signed(a_q[IMAG]));
        br      = PW'($signed(b_q[REAL]));
        bi      = PW'($signed(b_q[IMAG]));
        re_full = ar * br - ai * bi;
        im_full = ar * bi + ai * br;
    end

    assign unused_bits = ^{re_full, im_full};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            available <= 1'b0;
            p         <= '0;
        end else begin
            v1        <= ready;
            available <= v1;
            if (ready) begin
                a_q <= a;
                b_q <= b;
            end
            if (v1) begin
                p[REAL] <= re_full[FRAC +: OUT_BITS];
                p[IMAG] <= im_full[FRAC +: OUT_BITS];
            end
        end
    end

endmodule

// File: rtl/gate_row_accum.sv
// One gate-row dot product res = g0*a0 + g1*a1 on a shared multiplier.
// Define GATE_ACC_SAT_EN for saturating results and the sticky ovf port.
module gate_row_accum
    import qc_fix_pkg::*;
#(
    parameter int IN_BITS  = 37,
    parameter int OUT_BITS = 38
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    output logic                           in_ready,
    input  logic [0:1][0:1][IN_BITS-1:0]   g,
    input  logic [0:1][0:1][IN_BITS-1:0]   amp,
    output logic [0:1][OUT_BITS-1:0]       res,
    output logic                           res_valid,
    input  logic                           res_ready
`ifdef GATE_ACC_SAT_EN
    ,
    output logic                           ovf
`endif
);

    localparam int AW = OUT_BITS + 1;

    typedef enum logic [2:0] {
        IDLE, MUL0, WAIT0, MUL1, WAIT1, OUT
    } state_t;

    state_t                         state;
    logic [0:1][0:1][IN_BITS-1:0]   g_q;
    logic [0:1][0:1][IN_BITS-1:0]   a_q;
    logic [0:1][AW-1:0]             acc;
    logic [0:1][AW-1:0]             acc_nxt;
    logic [0:1][OUT_BITS-1:0]       red;
    logic [0:1][OUT_BITS-1:0]       prod;
    logic                           mul_ready;
    logic                           mul_avail;
    logic                           sel;
    logic                           done;

    assign sel  = (state == MUL1);
    assign done = (state == WAIT1) && mul_avail;

    complex_fix_mul_clocked #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
    ) u_mul (
        .clk      (clk),
        .reset_n  (reset_n),
        .ready    (mul_ready),
        .a        (g_q[sel]),
        .b        (a_q[sel]),
        .available(mul_avail),
        .p        (prod)
    );

`ifdef GATE_ACC_SAT_EN
    logic [1:0] clamp;
`endif

    always_comb begin
        acc_nxt = '0;
        red     = '0;
`ifdef GATE_ACC_SAT_EN
        clamp   = '0;
`endif
        for (int c = 0; c < 2; c++) begin
            acc_nxt[c] = acc[c] + AW'($signed(prod[c]));
`ifdef GATE_ACC_SAT_EN
            // the two top bits disagree only when the sum left the OUT_BITS range
            clamp[c] = acc_nxt[c][AW-1] ^ acc_nxt[c][AW-2];
            if (clamp[c])
                red[c] = acc_nxt[c][AW-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                          : {1'b0, {(OUT_BITS-1){1'b1}}};
            else
                red[c] = acc_nxt[c][OUT_BITS-1:0];
`else
            red[c] = acc_nxt[c][OUT_BITS-1:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            res       <= '0;
            acc       <= '0;
            g_q       <= '0;
            a_q       <= '0;
            mul_ready <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    g_q       <= g;
                    a_q       <= amp;
                    acc       <= '0;
                    in_ready  <= 1'b0;
                    mul_ready <= 1'b1;
                    state     <= MUL0;
                end
                MUL0: begin
                    mul_ready <= 1'b0;
                    state     <= WAIT0;
                end
                WAIT0: if (mul_avail) begin
                    acc       <= acc_nxt;
                    mul_ready <= 1'b1;
                    state     <= MUL1;
                end
                MUL1: begin
                    mul_ready <= 1'b0;
                    state     <= WAIT1;
                end
                WAIT1: if (mul_avail) begin
                    acc       <= acc_nxt;
                    res       <= red;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (res_ready) begin
                    res_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_ACC_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf <= 1'b0;
        else if (done && (|clamp))
            ovf <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_gate_row_accum.sv
// Randomized self-checking bench for gate_row_accum.
// Honours GATE_ACC_SAT_EN in both the DUT hookup and the reference model.
module tb_gate_row_accum;
    import qc_fix_pkg::*;

    localparam int IB   = 37;
    localparam int OB   = 38;
    localparam int FRAC = IB - 2;

    typedef logic [0:1][0:1][IB-1:0] row_t;
    typedef logic [0:1][OB-1:0]      out_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic res_ready = 1'b0;
    logic in_ready;
    logic res_valid;
    row_t g = '0;
    row_t amp = '0;
    out_t res;
`ifdef GATE_ACC_SAT_EN
    logic ovf;
`endif

    int checks = 0;
    int failures = 0;
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    gate_row_accum #(
        .IN_BITS (IB),
        .OUT_BITS(OB)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_ready (in_ready),
        .g        (g),
        .amp      (amp),
        .res      (res),
        .res_valid(res_valid),
        .res_ready(res_ready)
`ifdef GATE_ACC_SAT_EN
        ,
        .ovf      (ovf)
`endif
    );

    function automatic logic [IB-1:0] rv();
        return IB'({$urandom(), $urandom()});
    endfunction

    function automatic row_t rrow();
        row_t r;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 2; c++)
                r[k][c] = rv();
        return r;
    endfunction

    function automatic cplx_t cx(input logic [IB-1:0] re, input logic [IB-1:0] im);
        cplx_t v;
        v[REAL] = re;
        v[IMAG] = im;
        return v;
    endfunction

    // exact complex products, floor-scaled to Q(FRAC) and kept to OB bits,
    // then summed exactly and reduced by clamp or wrap
    function automatic out_t model(input row_t gg, input row_t aa, output bit o);
        logic signed [127:0] gr, gi, ar, ai, pr, pi;
        logic signed [127:0] sr, si, mx, mn;
        logic signed [OB-1:0] tr, ti;
        out_t r;
        sr = 0;
        si = 0;
        o = 1'b0;
        for (int k = 0; k < 2; k++) begin
            gr = $signed(gg[k][REAL]);
            gi = $signed(gg[k][IMAG]);
            ar = $signed(aa[k][REAL]);
            ai = $signed(aa[k][IMAG]);
            pr = (gr * ar - gi * ai) >>> FRAC;
            pi = (gr * ai + gi * ar) >>> FRAC;
            tr = pr[OB-1:0];
            ti = pi[OB-1:0];
            sr = sr + tr;
            si = si + ti;
        end
        mx = (128'sd1 <<< (OB - 1)) - 1;
        mn = -(128'sd1 <<< (OB - 1));
`ifdef GATE_ACC_SAT_EN
        if (sr > mx) begin sr = mx; o = 1'b1; end
        if (sr < mn) begin sr = mn; o = 1'b1; end
        if (si > mx) begin si = mx; o = 1'b1; end
        if (si < mn) begin si = mn; o = 1'b1; end
`endif
        r[REAL] = sr[OB-1:0];
        r[IMAG] = si[OB-1:0];
        return r;
    endfunction

    // drive one request; returns the cycle (accept cycle = 0) of the first res_valid
    task automatic do_txn(input row_t gg, input row_t aa, input int pulse_at,
                          input bit scramble, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        g = gg;
        amp = aa;
        start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == pulse_at);
            if (scramble) begin
                g = rrow();
                amp = rrow();
            end
        end while (!res_valid && lat < 40);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || res !== '0) begin
            failures++;
            $display("FAIL reset got in_ready=%b res_valid=%b res=%h exp 1 0 0",
                     in_ready, res_valid, res);
        end
`ifdef GATE_ACC_SAT_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got=%b exp=0", ovf);
        end
`endif
        reset_n = 1'b1;
        exp_ovf = 1'b0;
    endtask

    task automatic test_identity();
        row_t gg, aa;
        out_t exp;
        int lat;
        gg[0] = cx(ONE, '0);
        gg[1] = cx('0, '0);
        aa[0] = cx(ONE >> 1, ONE >> 2);
        aa[1] = cx((ONE >> 1) + (ONE >> 2), -(ONE >> 1));
        exp[REAL] = OB'(64'd1 << 34);
        exp[IMAG] = OB'(64'd1 << 33);
        res_ready = 1'b0;
        do_txn(gg, aa, -1, 1'b0, lat);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL identity_latency got=%0d exp=7", lat);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL identity_res got=%h exp=%h", res, exp);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_hadamard();
        row_t gg, aa;
        out_t exp;
        int lat, extra;
        gg[0] = cx(ONE >> 1, '0);
        gg[1] = cx(ONE >> 1, '0);
        aa[0] = cx(ONE >> 1, '0);
        aa[1] = cx(ONE >> 1, '0);
        exp[REAL] = OB'(64'd1 << 34);
        exp[IMAG] = '0;
        res_ready = 1'b1;
        do_txn(gg, aa, 2, 1'b0, lat);
        checks++;
        if (lat !== 7 || res !== exp) begin
            failures++;
            $display("FAIL hadamard_res got lat=%0d res=%h exp lat=7 res=%h", lat, res, exp);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL one_cycle_valid got res_valid=%b in_ready=%b exp 0 1",
                     res_valid, in_ready);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid || !in_ready) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL start_ignored got busy_cycles=%0d exp=0", extra);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        row_t gg, aa;
        out_t exp, r0;
        int lat, bad;
        bit o;
        gg = rrow();
        aa = rrow();
        exp = model(gg, aa, o);
        exp_ovf |= o;
        res_ready = 1'b0;
        do_txn(gg, aa, -1, 1'b0, lat);
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL bp_res got=%h exp=%h", res, exp);
        end
        r0 = exp;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res !== r0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold got unstable_cycles=%0d exp=0", bad);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got in_ready=%b res_valid=%b exp 1 0",
                     in_ready, res_valid);
        end
    endtask

    task automatic test_overflow();
        row_t gg, aa;
        out_t exp;
        logic [IB-1:0] m;
        int lat;
        bit o;
        m = {1'b0, {(IB-1){1'b1}}};
        for (int v = 0; v < 2; v++) begin
            gg[0] = cx(m, (v == 0) ? m : '0);
            gg[1] = gg[0];
            aa = gg;
            exp = model(gg, aa, o);
            exp_ovf |= o;
            res_ready = 1'b1;
            do_txn(gg, aa, -1, 1'b0, lat);
            checks++;
            if (res !== exp) begin
                failures++;
                $display("FAIL overflow_res%0d got=%h exp=%h", v, res, exp);
            end
`ifdef GATE_ACC_SAT_EN
            checks++;
            if (ovf !== exp_ovf) begin
                failures++;
                $display("FAIL overflow_flag%0d got=%b exp=%b", v, ovf, exp_ovf);
            end
`endif
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        row_t gg, aa;
        out_t exp;
        int lat, w;
        bit o;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        g = rrow();
        amp = rrow();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || res !== '0) begin
            failures++;
            $display("FAIL midop_reset got in_ready=%b res_valid=%b res=%h exp 1 0 0",
                     in_ready, res_valid, res);
        end
`ifdef GATE_ACC_SAT_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL midop_ovf got=%b exp=0", ovf);
        end
`endif
        exp_ovf = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        gg = rrow();
        aa = rrow();
        exp = model(gg, aa, o);
        exp_ovf |= o;
        res_ready = 1'b1;
        do_txn(gg, aa, -1, 1'b0, lat);
        checks++;
        if (lat !== 7 || res !== exp) begin
            failures++;
            $display("FAIL midop_next got lat=%0d res=%h exp lat=7 res=%h", lat, res, exp);
        end
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_input_hold();
        row_t gg, aa;
        out_t exp;
        int lat;
        bit o;
        for (int n = 0; n < 3; n++) begin
            gg = rrow();
            aa = rrow();
            exp = model(gg, aa, o);
            exp_ovf |= o;
            res_ready = 1'b1;
            do_txn(gg, aa, -1, 1'b1, lat);
            checks++;
            if (lat !== 7 || res !== exp) begin
                failures++;
                $display("FAIL input_hold%0d got lat=%0d res=%h exp lat=7 res=%h",
                         n, lat, res, exp);
            end
            @(negedge clk);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        row_t gg, aa;
        out_t exp;
        int lat, hold;
        bit o;
        for (int n = 0; n < 20; n++) begin
            gg = rrow();
            aa = rrow();
            if (n % 4 == 0) begin
                gg[1] = cx(ONE, '0);
                aa[0] = cx('0, ONE);
            end
            exp = model(gg, aa, o);
            exp_ovf |= o;
            hold = $urandom_range(0, 3);
            res_ready = (hold == 0);
            do_txn(gg, aa, -1, 1'b0, lat);
            checks++;
            if (lat !== 7 || res !== exp) begin
                failures++;
                $display("FAIL b2b%0d got lat=%0d res=%h exp lat=7 res=%h",
                         n, lat, res, exp);
            end
`ifdef GATE_ACC_SAT_EN
            checks++;
            if (ovf !== exp_ovf) begin
                failures++;
                $display("FAIL b2b_ovf%0d got=%b exp=%b", n, ovf, exp_ovf);
            end
`endif
            repeat (hold) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_hadamard();
        test_backpressure();
        test_overflow();
        test_reset_midop();
        test_input_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
